// File: rtl/reg_write_master_if.sv
// Host request and register-bus bundle for reg_write_master.
// master modport faces the block itself, slave faces the host/receiver.
interface reg_write_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [15:0] req_data;
  logic        bus_enable;
  logic        bus_phase;
  logic [3:0]  bus_address;
  logic [7:0]  bus_data;
  logic        busy;
  logic        done;
  logic [7:0]  write_count;

  modport master (
    input  req_valid, req_addr, req_data,
    output req_ready, bus_enable, bus_phase,
    output bus_address, bus_data,
    output busy, done, write_count
  );

  modport slave (
    output req_valid, req_addr, req_data,
    input  req_ready, bus_enable, bus_phase,
    input  bus_address, bus_data,
    input  busy, done, write_count
  );
endinterface

// File: rtl/reg_write_master.sv
// Serialises 16-bit register writes into low/high byte strobes.
// Define REG_WRITE_MASTER_FIFO_EN for a 4-entry request FIFO.
module reg_write_master #(
  parameter int BYTE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  reg_write_master_if.master bus
);
  localparam logic [2:0] LAST = 3'(BYTE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, GAP} state_t;

  state_t      r_state;
  logic [2:0]  r_cyc;
  logic [7:0]  r_hi;
  logic        r_en;
  logic        r_phase;
  logic [3:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_count;

  logic        w_acc;
  logic        w_start;
  logic [3:0]  w_nxt_addr;
  logic [15:0] w_nxt_data;

  assign w_acc = bus.req_valid && bus.req_ready;

`ifdef REG_WRITE_MASTER_FIFO_EN
  logic [3:0]  r_q_addr [4];
  logic [15:0] r_q_data [4];
  logic [1:0]  r_rd;
  logic [1:0]  r_wr;
  logic [2:0]  r_cnt;
  logic        w_open;
  logic        w_ne;
  logic        w_pop;
  logic        w_push;

  assign w_open  = (r_state == IDLE) || (r_state == GAP);
  assign w_ne    = (r_cnt != 3'd0);
  assign w_start = w_open && (w_ne || w_acc);
  assign w_pop   = w_start && w_ne;
  // empty FIFO: an accepted write goes straight onto the bus
  assign w_push  = w_acc && !(w_start && !w_ne);

  assign w_nxt_addr = w_ne ? r_q_addr[r_rd] : bus.req_addr;
  assign w_nxt_data = w_ne ? r_q_data[r_rd] : bus.req_data;
  assign bus.req_ready = rst_n && (r_cnt != 3'd4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd  <= 2'd0;
      r_wr  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_push) begin
        r_q_addr[r_wr] <= bus.req_addr;
        r_q_data[r_wr] <= bus.req_data;
        r_wr <= r_wr + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 2'd1;
      r_cnt <= r_cnt + {2'b0, w_push}
                     - {2'b0, w_pop};
    end
  end
`else
  assign w_start    = w_acc;
  assign w_nxt_addr = bus.req_addr;
  assign w_nxt_data = bus.req_data;
  assign bus.req_ready = rst_n && (r_state == IDLE);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cyc   <= 3'd0;
      r_hi    <= 8'd0;
      r_en    <= 1'b0;
      r_phase <= 1'b0;
      r_addr  <= 4'd0;
      r_data  <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, GAP: begin
          if (w_start) begin
            r_state <= LO;
            r_cyc   <= 3'd0;
            r_hi    <= w_nxt_data[15:8];
            r_en    <= 1'b1;
            r_phase <= 1'b0;
            r_addr  <= w_nxt_addr;
            r_data  <= w_nxt_data[7:0];
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        LO: begin
          if (r_cyc == LAST) begin
            r_state <= HI;
            r_cyc   <= 3'd0;
            r_phase <= 1'b1;
            r_data  <= r_hi;
          end else begin
            r_cyc <= r_cyc + 3'd1;
          end
        end
        HI: begin
          if (r_cyc == LAST) begin
            r_state <= GAP;
            r_cyc   <= 3'd0;
            r_en    <= 1'b0;
            r_phase <= 1'b0;
            r_addr  <= 4'd0;
            r_data  <= 8'd0;
            r_done  <= 1'b1;
            r_count <= r_count + 8'd1;
          end else begin
            r_cyc <= r_cyc + 3'd1;
          end
        end
      endcase
    end
  end

  assign bus.bus_enable  = r_en;
  assign bus.bus_phase   = r_phase;
  assign bus.bus_address = r_addr;
  assign bus.bus_data    = r_data;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.write_count = r_count;
endmodule

// File: tb/tb_reg_write_master.sv
// Bench for reg_write_master: BYTE_CYCLES=1 and =3 instances
// driven in lockstep and checked against a write-queue model.
module tb_reg_write_master;
  typedef struct packed {
    logic       rdy;
    logic       en;
    logic       ph;
    logic [3:0] ad;
    logic [7:0] da;
    logic       bsy;
    logic       dn;
    logic [7:0] cnt;
  } out_t;

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [15:0] d;
    logic        en;
    logic        ph;
    logic [3:0]  ad;
    logic [7:0]  da;
    logic        dn;
    logic [7:0]  cnt;
  } vec_t;

`ifdef REG_WRITE_MASTER_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  addr;
  logic [15:0] data;
  int          checks = 0;
  int          errors = 0;
  out_t        s1;
  out_t        s3;

  int          BCV [2] = '{1, 3};
  bit          m_act [2];
  int          m_t [2];
  logic [3:0]  m_a [2];
  logic [15:0] m_d [2];
  logic [7:0]  m_cnt [2];
  logic [19:0] m_q [2][4];
  int          m_qn [2];

  always #5 clk = ~clk;

  reg_write_master_if if1 ();
  reg_write_master_if if3 ();

  assign if1.req_valid = valid;
  assign if1.req_addr  = addr;
  assign if1.req_data  = data;
  assign if3.req_valid = valid;
  assign if3.req_addr  = addr;
  assign if3.req_data  = data;

  reg_write_master #(.BYTE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master)
  );
  reg_write_master #(.BYTE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.master)
  );

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               n, act, exp, $time);
    end
  endtask

  function automatic out_t mexp(int k, logic rn);
    out_t o;
    int   bc;
    bc = BCV[k];
    o = '0;
    o.rdy = rn && (FIFO ? (m_qn[k] < 4) : !m_act[k]);
    if (m_act[k] && m_t[k] < 2 * bc) begin
      o.en = 1'b1;
      o.ph = (m_t[k] >= bc);
      o.ad = m_a[k];
      o.da = o.ph ? m_d[k][15:8] : m_d[k][7:0];
    end
    o.bsy = m_act[k];
    o.dn  = m_act[k] && (m_t[k] == 2 * bc);
    o.cnt = m_cnt[k];
    return o;
  endfunction

  task automatic madv(int k, logic v, logic [3:0] a,
                      logic [15:0] d, logic rn);
    int   bc;
    logic acc;
    logic took;
    out_t o;
    bc = BCV[k];
    if (!rn) begin
      m_act[k] = 1'b0;
      m_t[k]   = 0;
      m_qn[k]  = 0;
      m_cnt[k] = 8'd0;
      return;
    end
    o = mexp(k, rn);
    acc  = v && o.rdy;
    took = 1'b0;
    if (m_act[k]) begin
      if (m_t[k] < 2 * bc) begin
        m_t[k]++;
        if (m_t[k] == 2 * bc) m_cnt[k] = m_cnt[k] + 8'd1;
      end else if (m_qn[k] > 0) begin
        {m_a[k], m_d[k]} = m_q[k][0];
        m_t[k] = 0;
        for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
        m_qn[k]--;
      end else if (acc) begin
        m_a[k] = a;
        m_d[k] = d;
        m_t[k] = 0;
        took = 1'b1;
      end else begin
        m_act[k] = 1'b0;
      end
    end else if (acc) begin
      m_act[k] = 1'b1;
      m_a[k] = a;
      m_d[k] = d;
      m_t[k] = 0;
      took = 1'b1;
    end
    if (acc && !took) begin
      m_q[k][m_qn[k]] = {a, d};
      m_qn[k]++;
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] a,
                       input logic [15:0] d, input logic rn);
    valid = v;
    addr  = a;
    data  = d;
    rst_n = rn;
    @(negedge clk);
    s1 = {if1.req_ready, if1.bus_enable, if1.bus_phase,
          if1.bus_address, if1.bus_data, if1.busy,
          if1.done, if1.write_count};
    s3 = {if3.req_ready, if3.bus_enable, if3.bus_phase,
          if3.bus_address, if3.bus_data, if3.busy,
          if3.done, if3.write_count};
    chk("model1", 32'(s1), 32'(mexp(0, rn)));
    chk("model3", 32'(s3), 32'(mexp(1, rn)));
    @(posedge clk);
    madv(0, v, a, d, rn);
    madv(1, v, a, d, rn);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 4'h0, 16'h0, 1'b0);
    cycle(1'b0, 4'h0, 16'h0, 1'b1);
  endtask

  vec_t        tbl [5];
  logic [9:0]  enb, phb, dnb;
  logic [7:0]  rdy8, en8;
  logic [5:0]  rdy6;
  int          n;
  bit          hit;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_t[k]   = 0;
      m_qn[k]  = 0;
      m_cnt[k] = 8'd0;
    end
    tbl[0] = '{v:1, a:4'h1, d:16'hA55A, en:0, ph:0,
               ad:4'h0, da:8'h00, dn:0, cnt:8'd0};
    tbl[1] = '{v:0, a:4'h0, d:16'h0000, en:1, ph:0,
               ad:4'h1, da:8'h5A, dn:0, cnt:8'd0};
    tbl[2] = '{v:0, a:4'hF, d:16'hFFFF, en:1, ph:1,
               ad:4'h1, da:8'hA5, dn:0, cnt:8'd0};
    tbl[3] = '{v:0, a:4'h0, d:16'h0000, en:0, ph:0,
               ad:4'h0, da:8'h00, dn:1, cnt:8'd1};
    tbl[4] = '{v:0, a:4'h0, d:16'h0000, en:0, ph:0,
               ad:4'h0, da:8'h00, dn:0, cnt:8'd1};

    do_reset();
    chk("reset", 32'(s1), 32'({1'b1, 24'h0}));

    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].v, tbl[i].a, tbl[i].d, 1'b1);
      chk("tbl", {14'h0, s1.en, s1.ph, s1.ad, s1.da,
                  s1.dn, s1.cnt[2:0]},
          {14'h0, tbl[i].en, tbl[i].ph, tbl[i].ad,
           tbl[i].da, tbl[i].dn, tbl[i].cnt[2:0]});
    end

    do_reset();
    cycle(1'b1, 4'h7, 16'hBEEF, 1'b1);
    for (int j = 0; j < 10; j++) begin
      cycle(1'b0, 4'h0, 16'h0, 1'b1);
      enb[j] = s3.en;
      phb[j] = s3.ph;
      dnb[j] = s3.dn;
    end
    chk("bc3_en", 32'(enb), 32'(10'b0000111111));
    chk("bc3_ph", 32'(phb), 32'(10'b0000111000));
    chk("bc3_dn", 32'(dnb), 32'(10'b0001000000));

`ifdef REG_WRITE_MASTER_FIFO_EN
    do_reset();
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, 4'(j), 16'(16'h1100 + j), 1'b1);
      rdy6[j] = s3.rdy;
    end
    chk("fifo_rdy", 32'(rdy6), 32'(6'b011111));
    n = 0;
    for (int j = 0; j < 40; j++) begin
      cycle(1'b0, 4'h0, 16'h0, 1'b1);
      if (s3.dn) n++;
    end
    chk("fifo_done", 32'(n), 32'd5);
`else
    do_reset();
    for (int j = 0; j < 8; j++) begin
      cycle(1'b1, 4'(j), 16'(16'h2200 + j), 1'b1);
      rdy8[j] = s1.rdy;
      en8[j]  = s1.en;
    end
    chk("hold_rdy", 32'(rdy8), 32'(8'b00010001));
    chk("hold_en", 32'(en8), 32'(8'b01100110));
`endif

    do_reset();
    cycle(1'b1, 4'h2, 16'h1234, 1'b1);
    cycle(1'b0, 4'h0, 16'h0, 1'b1);
    cycle(1'b0, 4'h0, 16'h0, 1'b0);
    chk("rst_hi", {30'h0, s1.ph, s1.rdy}, {30'h0, 2'b10});
    cycle(1'b0, 4'h0, 16'h0, 1'b1);
    chk("rst_after", {21'h0, s1.en, s1.bsy, s1.dn, s1.cnt},
        32'h0);
    cycle(1'b0, 4'h0, 16'h0, 1'b1);
    chk("rst_nodone", {23'h0, s1.dn, s1.cnt}, 32'h0);

    do_reset();
    n = 0;
    hit = 1'b0;
    for (int j = 0; j < 3000 && !hit; j++) begin
      cycle(1'b1, 4'($urandom), 16'($urandom), 1'b1);
      if (s1.dn) begin
        n++;
        if (n == 255) chk("cnt255", 32'(s1.cnt), 32'd255);
        if (n == 256) begin
          chk("wrap", {23'h0, s1.dn, s1.cnt}, {23'h0, 9'h100});
          hit = 1'b1;
        end
      end
    end
    if (!hit) chk("wrap_timeout", 32'(n), 32'd256);

    do_reset();
    for (int j = 0; j < 1500; j++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom),
            16'($urandom), ($urandom_range(0, 99) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
